switch_debounce_2ch: RTL and testbench

- Upstream input conditioner for the two-input comparator stage.
- Takes two raw board switch/button signals and synchronises each into the clock domain.
- Debounces each channel independently and presents stable A/B levels to the comparator.
- Also produces a one-cycle pulse whenever the debounced A/B pair changes, so downstream logic (LED latch, counters) can react once per real change.

---
 rtl/switch_debounce_2ch.sv | 74 +++++++
 tb/tb_switch_debounce_2ch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_2ch.sv
// rtl/switch_debounce_2ch.sv - two-channel synchronise-and-debounce front end for the A/B comparator
// Each raw switch is double-flopped, then accepted only after CNT_MAX consecutive differing samples.
module switch_debounce_2ch #(
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a_raw,
  input  logic sw_b_raw,
  output logic A,
  output logic B,
  output logic ab_changed
);

  typedef enum logic {STABLE, COUNTING} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       deb;
  logic [1:0]       upd;
  state_t           st  [2];
  logic [CNT_W-1:0] cnt [2];

  // bit 0 is channel A, bit 1 is channel B
  assign raw = {sw_b_raw, sw_a_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 2'b00;
      s2         <= 2'b00;
      deb        <= 2'b00;
      upd        <= 2'b00;
      ab_changed <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        st[i]  <= STABLE;
        cnt[i] <= '0;
      end
    end else begin
      s1         <= raw;
      s2         <= s1;
      // one pulse per update edge, even when both channels flip together
      ab_changed <= |upd;
      for (int i = 0; i < 2; i++) begin
        upd[i] <= 1'b0;
        if (st[i] == STABLE) begin
          if (s2[i] != deb[i]) begin
            st[i]  <= COUNTING;
            cnt[i] <= CNT_W'(1);
          end
        end else begin
          if (s2[i] == deb[i]) begin
            st[i]  <= STABLE;
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            deb[i] <= s2[i];
            upd[i] <= 1'b1;
            st[i]  <= STABLE;
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign A = deb[0];
  assign B = deb[1];

endmodule

// File: tb/tb_switch_debounce_2ch.sv
// tb/tb_switch_debounce_2ch.sv - scoreboard bench for switch_debounce_2ch
// Reference: an output flips once the last CNT_MAX synchronised samples all disagree with it.
module tb_switch_debounce_2ch;

  localparam int CNT_MAX = 4;
  localparam int CNT_W   = 3;
  localparam int L       = CNT_MAX + 2;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic sw_a_raw = 1'b1;
  logic sw_b_raw = 1'b1;
  logic A;
  logic B;
  logic ab_changed;

  int n_cmp     = 0;
  int n_bad     = 0;
  int cyc       = 0;
  int pulse_cnt = 0;
  int p0;

  bit ha [L];
  bit hb [L];
  bit ma = 1'b0;
  bit mb = 1'b0;
  bit fa;
  bit fb;
  int exp_q [$];

  always #5 clk = ~clk;

  switch_debounce_2ch #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_a_raw   (sw_a_raw),
    .sw_b_raw   (sw_b_raw),
    .A          (A),
    .B          (B),
    .ab_changed (ab_changed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // raw sampled at edge t reaches the debouncer's decision at edge t+2
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        ha[k] = 1'b0;
        hb[k] = 1'b0;
      end
      ma = 1'b0;
      mb = 1'b0;
      exp_q.delete();
    end else begin
      fa = 1'b1;
      fb = 1'b1;
      for (int j = 0; j < CNT_MAX; j++) begin
        if (ha[L-2-j] == ma) fa = 1'b0;
        if (hb[L-2-j] == mb) fb = 1'b0;
      end
      if (fa) ma = !ma;
      if (fb) mb = !mb;
      if (fa || fb) exp_q.push_back(cyc + 2);
      for (int k = 0; k < L - 1; k++) begin
        ha[k] = ha[k+1];
        hb[k] = hb[k+1];
      end
      ha[L-1] = sw_a_raw;
      hb[L-1] = sw_b_raw;
    end
  end

  always @(negedge clk) begin
    check("ab_level", 32'({A, B}), 32'({ma, mb}));
    if (ab_changed === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check("ab_changed_unexpected", 1, 0);
      else check("ab_changed_cycle", cyc, exp_q.pop_front());
    end else if (ab_changed !== 1'b0) begin
      check("ab_changed_known", 32'(ab_changed), 0);
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      check("ab_changed_missing", 0, 1);
      void'(exp_q.pop_front());
    end
  end

  task automatic hold(input bit a, input bit b, input int n);
    sw_a_raw = a;
    sw_b_raw = b;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic async_reset_pulse(input int dly);
    @(posedge clk);
    #(dly);
    rst_n = 1'b0;
    #1;
    check("async_reset_A", 32'(A), 0);
    check("async_reset_B", 32'(B), 0);
    check("async_reset_pulse", 32'(ab_changed), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset held with both raw inputs high, then release
    #21;
    check("reset_A", 32'(A), 0);
    check("reset_B", 32'(B), 0);
    check("reset_pulse", 32'(ab_changed), 0);
    #30;
    rst_n = 1'b1;
    p0 = pulse_cnt;
    hold(1, 1, 12);
    check("t1_AB", 32'({A, B}), 32'b11);
    check("t1_pulses", pulse_cnt - p0, 1);

    // 2: short bounces on A are rejected, long hold accepted
    hold(0, 0, 20);
    p0 = pulse_cnt;
    repeat (5) begin
      hold(1, 0, 3);
      hold(0, 0, 2);
    end
    check("t2_bounce_A", 32'(A), 0);
    check("t2_bounce_pulses", pulse_cnt - p0, 0);
    hold(1, 0, 12);
    check("t2_A", 32'(A), 1);
    check("t2_pulses", pulse_cnt - p0, 1);

    // 3: simultaneous step yields one pulse
    hold(0, 0, 20);
    p0 = pulse_cnt;
    hold(1, 1, 12);
    check("t3_AB", 32'({A, B}), 32'b11);
    check("t3_pulses", pulse_cnt - p0, 1);

    // 4: sweep 00,01,10,11,00
    hold(0, 0, 20);
    p0 = pulse_cnt;
    for (int v = 1; v <= 4; v++) begin
      hold(1'((v % 4) >> 1), 1'(v % 4 & 1), 20);
      check("t4_level", 32'({A, B}), 32'(v % 4));
    end
    check("t4_pulses", pulse_cnt - p0, 4);

    // 5: reset lands mid-count, then a full fresh qualification
    sw_a_raw = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_A", 32'(A), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pulse_cnt;
    hold(1, 0, 3);
    check("t5_not_yet", 32'(A), 0);
    hold(1, 0, 12);
    check("t5_A", 32'(A), 1);
    check("t5_pulses", pulse_cnt - p0, 1);

    // 6: B one edge behind A, then A chatters while B qualifies
    hold(0, 0, 20);
    p0 = pulse_cnt;
    hold(1, 0, 1);
    hold(1, 1, 20);
    check("t6_pulses", pulse_cnt - p0, 2);
    p0 = pulse_cnt;
    for (int k = 0; k < 8; k++) hold(1'(k & 1), 0, 1);
    hold(1, 0, 20);
    check("t6_B", 32'(B), 0);
    check("t6_pulses_b", pulse_cnt - p0, 1);

    // random soak with occasional asynchronous resets
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 24) == 0) async_reset_pulse(int'($urandom_range(1, 3)));
      else hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    end

    hold(sw_a_raw, sw_b_raw, 20);
    check("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
